mem_arbiter: RTL and testbench

Shares one single-ported memory between the instruction-fetch port and the load/store (data) port of the RV32I core. The arbiter latches one request at a time, drives the shared memory handshake, and returns read data to the owning requester as a one-cycle valid pulse. Data accesses have priority, and a streak limit prevents fetch starvation. The block sits between the pipeline's IF/MEM stages and the unified memory.

---
 rtl/mem_arbiter_if.sv | 52 +++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared-memory handshake of mem_arbiter.
// master = arbiter side, slave = requesters plus memory (the environment).
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_be;
  logic                  d_valid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport master (
    input  if_req, if_addr,
    output if_valid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_valid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output busy
  );

  modport slave (
    output if_req, if_addr,
    input  if_valid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_valid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-ported memory; zero-wait access = grant->valid in 2 cycles, 3-cycle period.
// Back-pressure: mem_req and the mem_* copy hold until mem_gnt; requesters hold req until their valid pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int SW       = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  grant_d;
  logic                  grant_f;
  logic                  capture;

  logic                  owner_d;
  logic [SW-1:0]         streak;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [BE_WIDTH-1:0]   mem_be_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_f   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless fetch has already waited out a full streak.
        if (bus.d_req && !(bus.if_req && streak == STREAK_MAX)) begin
          grant_d = 1'b1;
        end else if (bus.if_req) begin
          grant_f = 1'b1;
        end
        if (grant_d || grant_f) begin
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (bus.mem_gnt) begin
          if (bus.mem_rvalid) begin
            capture   = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d     <= 1'b0;
      streak      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_d) begin
        owner_d     <= 1'b1;
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_be_q    <= bus.d_be;
        if (bus.if_req) begin
          streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end else if (grant_f) begin
        owner_d     <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
        streak      <= '0;
      end

      // Store acknowledges carry no data, so d_rdata keeps the last load.
      if (capture) begin
        if (!owner_d) begin
          if_rdata_q <= bus.mem_rdata;
        end else if (!mem_we_q) begin
          d_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.mem_req   = (state == REQ);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.if_valid  = (state == RESP) && !owner_d;
  assign bus.d_valid   = (state == RESP) && owner_d;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: each task drives one scenario and checks inline.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MAX_D_STREAK(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== 70'd0) begin
      failures++;
      $display("FAIL reset_mem got req=%0b we=%0b addr=%h wdata=%h be=%h want all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
    end
    checks++;
    if ({bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata, bus.busy} !== 67'd0) begin
      failures++;
      $display("FAIL reset_resp got ifv=%0b dv=%0b ifr=%h dr=%h busy=%0b want all 0",
               bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata, bus.busy);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.mem_req} !== 2'b00) begin
      failures++;
      $display("FAIL reset_release got busy=%0b req=%0b want 0 0", bus.busy, bus.mem_req);
    end
  endtask

  task automatic test_fetch_zero_wait;
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.busy} !== {1'b1, 1'b0, 4'hF, 1'b1}) begin
      failures++;
      $display("FAIL fetch_req got req=%0b we=%0b be=%h busy=%0b want 1 0 f 1",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.busy);
    end
    checks++;
    if (bus.mem_addr !== 32'h100) begin
      failures++;
      $display("FAIL fetch_addr got %h want 00000100", bus.mem_addr);
    end
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00500093;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 32'hFFFFFFFF;
    checks++;
    if ({bus.if_valid, bus.d_valid} !== 2'b10) begin
      failures++;
      $display("FAIL fetch_valid got ifv=%0b dv=%0b want 1 0", bus.if_valid, bus.d_valid);
    end
    checks++;
    if (bus.if_rdata !== 32'h00500093) begin
      failures++;
      $display("FAIL fetch_rdata got %h want 00500093", bus.if_rdata);
    end
    bus.if_req = 0;
    tick();
    checks++;
    if ({bus.if_valid, bus.d_valid, bus.busy} !== 3'b000) begin
      failures++;
      $display("FAIL fetch_idle got ifv=%0b dv=%0b busy=%0b want 0 0 0",
               bus.if_valid, bus.d_valid, bus.busy);
    end
  endtask

  task automatic test_store_wait;
    int dv;
    int iv;
    dv = 0; iv = 0;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEADBEEF; bus.d_be = 4'hF;
    for (int c = 1; c <= 8; c++) begin
      tick();
      dv += int'(bus.d_valid);
      iv += int'(bus.if_valid);
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be} !== {1'b1, 32'h2000, 32'hDEADBEEF, 4'hF}) begin
        failures++;
        $display("FAIL store_hold c=%0d got we=%0b addr=%h wdata=%h be=%h want 1 2000 deadbeef f",
                 c, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      checks++;
      if (bus.mem_req !== (c <= 3) || bus.busy !== (c <= 7)) begin
        failures++;
        $display("FAIL store_req c=%0d got req=%0b busy=%0b want %0b %0b",
                 c, bus.mem_req, bus.busy, (c <= 3), (c <= 7));
      end
      if (c == 7) begin
        checks++;
        if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'h0) begin
          failures++;
          $display("FAIL store_resp got dv=%0b dr=%h want 1 00000000", bus.d_valid, bus.d_rdata);
        end
        bus.d_req = 0;
      end
      bus.mem_gnt = (c == 3);
      bus.mem_rvalid = (c == 6);
      bus.mem_rdata = 32'hBAD0BAD0;
    end
    checks++;
    if (dv != 1 || iv != 0) begin
      failures++;
      $display("FAIL store_pulses got d=%0d if=%0d want 1 0", dv, iv);
    end
  endtask

  task automatic test_load_after_store;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_be = 4'hF;
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 32'h2000}) begin
      failures++;
      $display("FAIL load_req got req=%0b we=%0b addr=%h want 1 0 2000",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h12345678;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    checks++;
    if ({bus.d_valid, bus.if_valid} !== 2'b10 || bus.d_rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL load_resp got dv=%0b ifv=%0b dr=%h want 1 0 12345678",
               bus.d_valid, bus.if_valid, bus.d_rdata);
    end
    checks++;
    if (bus.if_rdata !== 32'h00500093) begin
      failures++;
      $display("FAIL load_if_rdata got %h want 00500093", bus.if_rdata);
    end
    bus.d_req = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    int g;
    g = 0;
    bus.if_req = 1; bus.if_addr = 32'h400;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h800; bus.d_be = 4'h3;
    for (int c = 0; c < 40 && g < 10; c++) begin
      tick();
      if (bus.mem_req) begin
        // Expected order with a streak limit of 4: D D D D F D D D D F
        checks++;
        if ((bus.mem_addr == 32'h400) !== (g % 5 == 4)) begin
          failures++;
          $display("FAIL grant_order g=%0d got addr=%h want %s", g, bus.mem_addr,
                   (g % 5 == 4) ? "fetch" : "data");
        end
        g++;
      end
      bus.mem_gnt = bus.mem_req;
      bus.mem_rvalid = bus.mem_req;
      bus.mem_rdata = 32'h0000AAAA;
    end
    bus.if_req = 0; bus.d_req = 0;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    tick();
    checks++;
    if (g != 10 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL grant_count got grants=%0d busy=%0b want 10 0", g, bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    bus.if_req = 1; bus.if_addr = 32'h300;
    tick();
    bus.mem_gnt = 1; bus.mem_rvalid = 0;
    tick();
    bus.mem_gnt = 0;
    checks++;
    if ({bus.busy, bus.mem_req} !== 2'b10) begin
      failures++;
      $display("FAIL mid_wait got busy=%0b req=%0b want 1 0", bus.busy, bus.mem_req);
    end
    rst = 1; bus.if_req = 0;
    #1;
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be,
         bus.if_valid, bus.d_valid, bus.if_rdata, bus.d_rdata, bus.busy} !== 137'd0) begin
      failures++;
      $display("FAIL mid_reset got req=%0b addr=%h be=%h ifr=%h dr=%h busy=%0b want all 0",
               bus.mem_req, bus.mem_addr, bus.mem_be, bus.if_rdata, bus.d_rdata, bus.busy);
    end
    tick();
    rst = 0;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h77777777;
    for (int c = 0; c < 3; c++) begin
      tick();
      bus.mem_rvalid = 0;
      pulses += int'(bus.if_valid) + int'(bus.d_valid) + int'(bus.busy);
    end
    checks++;
    if (pulses != 0 || bus.if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL stray_rvalid got activity=%0d ifr=%h want 0 00000000", pulses, bus.if_rdata);
    end
    bus.if_req = 1; bus.if_addr = 32'h104;
    tick();
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'h00A00113;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    checks++;
    if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h00A00113) begin
      failures++;
      $display("FAIL post_reset_fetch got ifv=%0b ifr=%h want 1 00a00113", bus.if_valid, bus.if_rdata);
    end
    bus.if_req = 0;
    tick();
  endtask

  task automatic test_backpressure;
    int bad;
    bad = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h3000; bus.d_be = 4'hF;
    tick();
    for (int i = 0; i < 11; i++) begin
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h3000 || bus.mem_we !== 1'b0 ||
          bus.busy !== 1'b1 || bus.d_valid !== 1'b0 || bus.if_valid !== 1'b0) begin
        bad++;
      end
      if (i == 0) begin
        bus.d_addr = 32'h9999; bus.d_we = 1;
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL backpressure_hold got %0d bad cycles want 0 (addr=%h req=%0b)",
               bad, bus.mem_addr, bus.mem_req);
    end
    bus.mem_gnt = 1; bus.mem_rvalid = 1; bus.mem_rdata = 32'hCAFEF00D;
    tick();
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    checks++;
    if (bus.d_valid !== 1'b1 || bus.d_rdata !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL backpressure_resp got dv=%0b dr=%h want 1 cafef00d", bus.d_valid, bus.d_rdata);
    end
    bus.d_req = 0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.d_valid !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_idle got busy=%0b dv=%0b want 0 0", bus.busy, bus.d_valid);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fetch_zero_wait();
    test_store_wait();
    test_load_after_store();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
